// File: rtl/serial_shift_unit.sv
`default_nettype none
// ============================================================================
//  Module   : serial_shift_unit
//  Brief    : Multicycle shifter. Loads an operand on start, then shifts it
//             one bit per clock (SLL/SRL/SRA, optional ROR) until the
//             requested count is exhausted, then pulses done for one cycle.
//  Options  : SERIAL_SHIFT_ROR_EN - when defined, shift_type 2'b11 rotates
//             right; otherwise 2'b11 is decoded as SRA.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_shift_unit #(
    parameter int WIDTH = 32,   // operand / result width
    parameter int NW    = 5     // count width, 2**NW must cover WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       shift_type,
    input  logic [WIDTH-1:0] data_in,
    input  logic [NW-1:0]    n,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [1:0] c_SLL = 2'b00;
    localparam logic [1:0] c_SRL = 2'b01;
    localparam logic [1:0] c_SRA = 2'b10;
    localparam logic [1:0] c_ROR = 2'b11;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [NW-1:0]    cnt_q,   cnt_d;
    logic [1:0]       type_q,  type_d;
    logic [WIDTH-1:0] w_step;

    // One-position shift of the working register by the latched type.
    always_comb begin
        w_step = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
        case (type_q)
            c_SLL:   w_step = {data_q[WIDTH-2:0], 1'b0};
            c_SRL:   w_step = {1'b0, data_q[WIDTH-1:1]};
            c_SRA:   w_step = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
`ifdef SERIAL_SHIFT_ROR_EN
            c_ROR:   w_step = {data_q[0], data_q[WIDTH-1:1]};
`else
            // Without the rotate option the top encoding aliases SRA.
            c_ROR:   w_step = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
`endif
            default: w_step = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
        endcase
    end

    // Next-state, datapath load/shift and handshake outputs.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        type_d  = type_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    data_d  = data_in;
                    cnt_d   = n;
                    type_d  = shift_type;
                    // A zero count skips straight to the completion cycle.
                    state_d = (n == '0) ? FINISH : SHIFT;
                end
            end
            SHIFT: begin
                busy   = 1'b1;
                data_d = w_step;
                cnt_d  = cnt_q - NW'(1);
                // Counter at 1 means this edge performs the final shift.
                if (cnt_q == NW'(1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            type_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            type_q  <= type_d;
        end
    end

    assign data_out = data_q;

endmodule
`default_nettype wire
